// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel tick, h/v counters, active-area coords, sync/blank.
// Optional VGA_SYNC_DELAY_EN delays vga_hs/vga_vs/vga_blank_n by SYNC_DELAY ticks.
module vga_timing_gen #(
  parameter int CLK_DIV       = 2,
  parameter int H_SYNC_WAIT   = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int V_SYNC_WAIT   = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int SYNC_DELAY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic       vga_clk,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic [9:0] xcoord,
  output logic [9:0] ycoord,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n
);

  localparam int H_TOTAL = H_SYNC_WAIT + H_BACK_PORCH
                         + H_ACTIVE + H_FRONT_PORCH;
  localparam int V_TOTAL = V_SYNC_WAIT + V_BACK_PORCH
                         + V_ACTIVE + V_FRONT_PORCH;
  localparam int H_START = H_SYNC_WAIT + H_BACK_PORCH;
  localparam int V_START = V_SYNC_WAIT + V_BACK_PORCH;
  localparam int DW      = $clog2(CLK_DIV);
`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = SYNC_DELAY;
`else
  // SYNC_DELAY has no effect without the delay build
  localparam int DLY = 0 * SYNC_DELAY;
`endif

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic [9:0]    x_nxt;
  logic [9:0]    y_nxt;
  logic          h_act;
  logic          v_act;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          hs_r;
  logic          vs_r;

  always_comb begin
    tick    = (div_cnt == DW'(CLK_DIV - 1));
    div_nxt = tick ? '0 : div_cnt + 1'b1;
    h_wrap  = (hcount == 10'(H_TOTAL - 1));
    v_wrap  = (vcount == 10'(V_TOTAL - 1));
    h_nxt   = hcount;
    v_nxt   = vcount;
    if (tick) begin
      h_nxt = h_wrap ? '0 : hcount + 10'd1;
      if (h_wrap)
        v_nxt = v_wrap ? '0 : vcount + 10'd1;
    end
    // decodes use next counts so they land on the counter edge
    h_act  = (h_nxt >= 10'(H_START))
          && (h_nxt < 10'(H_START + H_ACTIVE));
    v_act  = (v_nxt >= 10'(V_START))
          && (v_nxt < 10'(V_START + V_ACTIVE));
    x_nxt  = h_act ? h_nxt - 10'(H_START) : '0;
    y_nxt  = v_act ? v_nxt - 10'(V_START) : '0;
    hs_nxt = (h_nxt >= 10'(H_SYNC_WAIT));
    vs_nxt = (v_nxt >= 10'(V_SYNC_WAIT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      vga_clk     <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      xcoord      <= '0;
      ycoord      <= '0;
      active      <= 1'b0;
      hs_r        <= 1'b0;
      vs_r        <= 1'b0;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      vga_clk     <= (div_nxt >= DW'(CLK_DIV / 2));
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      xcoord      <= x_nxt;
      ycoord      <= y_nxt;
      active      <= h_act && v_act;
      hs_r        <= hs_nxt;
      vs_r        <= vs_nxt;
      pix_tick    <= tick;
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
    end
  end

  if (DLY == 0) begin : g_nodly
    assign vga_hs      = hs_r;
    assign vga_vs      = vs_r;
    assign vga_blank_n = active;
  end else begin : g_dly
    logic [DLY-1:0] hs_p;
    logic [DLY-1:0] vs_p;
    logic [DLY-1:0] bl_p;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hs_p <= '0;
        vs_p <= '0;
        bl_p <= '0;
      end else if (tick) begin
        hs_p[0] <= hs_r;
        vs_p[0] <= vs_r;
        bl_p[0] <= active;
        for (int i = 1; i < DLY; i++) begin
          hs_p[i] <= hs_p[i-1];
          vs_p[i] <= vs_p[i-1];
          bl_p[i] <= bl_p[i-1];
        end
      end
    end

    assign vga_hs      = hs_p[DLY-1];
    assign vga_vs      = vs_p[DLY-1];
    assign vga_blank_n = bl_p[DLY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-size and small-raster instances
// checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pix_tick;
    logic       vga_clk;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [9:0] xcoord;
    logic [9:0] ycoord;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  bit   run   = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  logic a_pix, a_vclk, a_act, a_ls, a_fs, a_hs, a_vs, a_bn;
  logic [9:0] a_h, a_v, a_x, a_y;
  logic b_pix, b_vclk, b_act, b_ls, b_fs, b_hs, b_vs, b_bn;
  logic [9:0] b_h, b_v, b_x, b_y;
  outs_t a_o, b_o;

  assign a_o = {a_pix, a_vclk, a_h, a_v, a_x, a_y,
                a_act, a_ls, a_fs, a_hs, a_vs, a_bn};
  assign b_o = {b_pix, b_vclk, b_h, b_v, b_x, b_y,
                b_act, b_ls, b_fs, b_hs, b_vs, b_bn};

  vga_timing_gen u_a (
    .clk(clk), .reset(rst_a),
    .pix_tick(a_pix), .vga_clk(a_vclk),
    .hcount(a_h), .vcount(a_v),
    .xcoord(a_x), .ycoord(a_y),
    .active(a_act), .line_start(a_ls),
    .frame_start(a_fs), .vga_hs(a_hs),
    .vga_vs(a_vs), .vga_blank_n(a_bn)
  );

  vga_timing_gen #(
    .CLK_DIV(3),
    .H_SYNC_WAIT(4), .H_BACK_PORCH(3),
    .H_ACTIVE(8), .H_FRONT_PORCH(2),
    .V_SYNC_WAIT(2), .V_BACK_PORCH(2),
    .V_ACTIVE(5), .V_FRONT_PORCH(1)
  ) u_b (
    .clk(clk), .reset(rst_b),
    .pix_tick(b_pix), .vga_clk(b_vclk),
    .hcount(b_h), .vcount(b_v),
    .xcoord(b_x), .ycoord(b_y),
    .active(b_act), .line_start(b_ls),
    .frame_start(b_fs), .vga_hs(b_hs),
    .vga_vs(b_vs), .vga_blank_n(b_bn)
  );

  // raster position from clocks elapsed since reset release
  function automatic outs_t model(longint n, int cd,
      int hsw, int hbp, int hac, int hfp,
      int vsw, int vbp, int vac, int vfp);
    outs_t  m;
    longint p  = n / cd;
    int     d  = int'(n % cd);
    int     ht = hsw + hbp + hac + hfp;
    int     vt = vsw + vbp + vac + vfp;
    int     h  = int'(p % ht);
    int     v  = int'((p / ht) % vt);
    int     hs = hsw + hbp;
    int     vs = vsw + vbp;
    bit     ha = (h >= hs) && (h < hs + hac);
    bit     va = (v >= vs) && (v < vs + vac);
    m.pix_tick    = (n > 0) && (d == 0);
    m.vga_clk     = (d >= cd / 2);
    m.hcount      = 10'(h);
    m.vcount      = 10'(v);
    m.xcoord      = ha ? 10'(h - hs) : 10'd0;
    m.ycoord      = va ? 10'(v - vs) : 10'd0;
    m.active      = ha && va;
    m.line_start  = m.pix_tick && (h == 0);
    m.frame_start = m.line_start && (v == 0);
    m.vga_hs      = (h >= hsw);
    m.vga_vs      = (v >= vsw);
    m.vga_blank_n = m.active;
    return m;
  endfunction

  function automatic outs_t model_a(longint n);
    return model(n, 2, 96, 48, 640, 16, 2, 33, 480, 10);
  endfunction

  function automatic outs_t model_b(longint n);
    return model(n, 3, 4, 3, 8, 2, 2, 2, 5, 1);
  endfunction

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  endtask

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h",
               nm, $time, act, exp);
      if (fails >= 100) summary();
    end
  endtask

  longint cyc_a = 0;
  longint cyc_b = 0;

  always @(posedge clk or negedge rst_a)
    if (!rst_a) cyc_a <= 0;
    else        cyc_a <= cyc_a + 1;

  always @(posedge clk or negedge rst_b)
    if (!rst_b) cyc_b <= 0;
    else        cyc_b <= cyc_b + 1;

  always @(negedge clk) begin
    if (run) begin
      check("cycle_a", a_o, model_a(cyc_a));
      check("cycle_b", b_o, model_b(cyc_b));
    end
  end

  task automatic release_a();
    int n = 0;
    @(negedge clk);
    #1 rst_a = 1'b1;
    while (!a_pix && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_tick_clocks", n, 2);
    check("first_tick_hcount", a_h, 1);
  endtask

  task automatic wait_a(int h, int v);
    int k = 0;
    while (!(a_h == 10'(h) && a_v == 10'(v)) && k < 60000) begin
      @(negedge clk);
      k++;
    end
    check("wait_a_budget", k < 60000, 1);
  endtask

  task automatic wait_fs_b(output longint t);
    int k = 0;
    @(negedge clk);
    while (!b_fs && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("wait_frame_budget", k < 2000, 1);
    t = cyc_b;
  endtask

  task automatic flow_a();
    int k;
    repeat (5) @(negedge clk);
    check("reset_hold_a", a_o, 0);
    release_a();
    wait_a(799, 0);
    k = 0;
    @(negedge clk);
    while (!a_pix && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("wrap_hcount", a_h, 0);
    check("wrap_vcount", a_v, 1);
    check("wrap_line_start", a_ls, 1);
    check("wrap_hs", a_hs, 0);
    @(negedge clk);
    check("line_start_width", a_ls, 0);
    wait_a(95, 1);
    check("hs_low_95", a_hs, 0);
    wait_a(96, 1);
    check("hs_high_96", a_hs, 1);
    wait_a(143, 35);
    check("act_143", a_act, 0);
    check("x_143", a_x, 0);
    wait_a(144, 35);
    check("act_144", a_act, 1);
    check("x_144", a_x, 0);
    check("y_144", a_y, 0);
    wait_a(783, 35);
    check("x_783", a_x, 639);
    wait_a(784, 35);
    check("act_784", a_act, 0);
    wait_a(300, 36);
    @(posedge clk);
    #2 rst_a = 1'b0;
    #1 check("async_reset_a", a_o, 0);
    repeat (5) @(negedge clk);
    release_a();
    repeat (200) @(negedge clk);
  endtask

  task automatic flow_b();
    longint t1, t2;
    repeat (5) @(negedge clk);
    @(negedge clk);
    #1 rst_b = 1'b1;
    wait_fs_b(t1);
    check("frame_h_b", b_h, 0);
    check("frame_v_b", b_v, 0);
    check("frame_ls_b", b_ls, 1);
    wait_fs_b(t2);
    check("frame_period_b", t2 - t1, 510);
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 700)) @(posedge clk);
      #($urandom_range(1, 3)) rst_b = 1'b0;
      #1 check("async_reset_b", b_o, 0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      #1 rst_b = 1'b1;
    end
  endtask

  initial begin
    outs_t m;
    m = model_a(2);
    check("pin_first_tick", {m.pix_tick, m.hcount}, {1'b1, 10'd1});
    m = model_a(1600);
    check("pin_line", {m.line_start, m.hcount, m.vcount},
          {1'b1, 10'd0, 10'd1});
    m = model_a(2 * (35 * 800 + 144));
    check("pin_act", {m.active, m.xcoord, m.ycoord},
          {1'b1, 10'd0, 10'd0});
    m = model_a(2 * (35 * 800 + 783));
    check("pin_x639", m.xcoord, 639);
    m = model_a(840000);
    check("pin_frame", {m.frame_start, m.hcount, m.vcount},
          {1'b1, 10'd0, 10'd0});
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    run   = 1'b1;
    fork
      flow_a();
      flow_b();
    join
    summary();
  end

endmodule
